// File: rtl/fetch_fill_buffer.sv
// rtl/fetch_fill_buffer.sv - icache fill buffer: tags line fetches, accepts out-of-order fills, delivers in order
package fetch_fill_buffer_pkg;
    localparam int ADDR_W      = 32;
    localparam int ID_W        = 4;
    localparam int CL_SZ_WORDS = 4;

    typedef logic [31:0] t_word;

    typedef struct packed {
        t_word [CL_SZ_WORDS-1:0] W;
    } t_cl;

    typedef struct packed {
        logic              valid;
        logic [ID_W-1:0]   id;
        logic [ADDR_W-1:0] addr;
    } t_mem_req;

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
        t_cl             data;
    } t_mem_rsp;
endpackage

module fetch_fill_buffer
    import fetch_fill_buffer_pkg::*;
#(
    parameter int NUM_ENTRIES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fe_fb_req_valid,
    input  logic [ADDR_W-1:0] fe_fb_req_addr,
    output logic              fe_fb_req_ready,
    input  logic              flush,
    output t_mem_req          fb_ic_req_nnn,
    input  t_mem_rsp          ic_fb_rsp_nnn,
    output logic              fb_fe_rsp_valid,
    output logic [ADDR_W-1:0] fb_fe_rsp_addr,
    output t_cl               fb_fe_rsp_data,
    input  logic              fe_fb_rsp_ready
);
    localparam int PW  = $clog2(NUM_ENTRIES);
    localparam int OFS = $clog2(CL_SZ_WORDS * 4);

    typedef enum logic [1:0] {
        E_IDLE   = 2'd0,
        E_PEND   = 2'd1,
        E_FILLED = 2'd2,
        E_DRAIN  = 2'd3
    } t_entry_state;

    t_entry_state            state_q [NUM_ENTRIES];
    logic [ADDR_W-1:0]       addr_q  [NUM_ENTRIES];
    t_cl                     data_q  [NUM_ENTRIES];
    logic [PW-1:0]           alloc_ptr;
    logic [PW-1:0]           dlvr_ptr;
    logic [NUM_ENTRIES-1:0]  rsp_hit;
    logic                    accept;
    logic                    deliver;
    logic [ADDR_W-1:0]       line_addr;

    assign line_addr       = fe_fb_req_addr & ~ADDR_W'((1 << OFS) - 1);
    assign fe_fb_req_ready = ~reset & ~flush & (state_q[alloc_ptr] == E_IDLE);
    assign fb_fe_rsp_valid = ~reset & ~flush & (state_q[dlvr_ptr] == E_FILLED);
    assign fb_fe_rsp_addr  = addr_q[dlvr_ptr];
    assign fb_fe_rsp_data  = data_q[dlvr_ptr];
    assign accept          = fe_fb_req_valid & fe_fb_req_ready;
    assign deliver         = fb_fe_rsp_valid & fe_fb_rsp_ready;

    always_comb begin
        rsp_hit = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            rsp_hit[i] = ic_fb_rsp_nnn.valid & (ic_fb_rsp_nnn.id == ID_W'(i));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                state_q[i] <= E_IDLE;
            end
            alloc_ptr     <= '0;
            dlvr_ptr      <= '0;
            fb_ic_req_nnn <= '0;
        end else begin
            fb_ic_req_nnn <= '0;
            if (accept) begin
                fb_ic_req_nnn.valid <= 1'b1;
                fb_ic_req_nnn.id    <= ID_W'(alloc_ptr);
                fb_ic_req_nnn.addr  <= line_addr;
                alloc_ptr           <= alloc_ptr + PW'(1);
            end
            // Flush realigns delivery to the allocation point; in-flight ids stay reserved via DRAIN.
            if (flush) begin
                dlvr_ptr <= alloc_ptr;
            end else if (deliver) begin
                dlvr_ptr <= dlvr_ptr + PW'(1);
            end
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                if (flush) begin
                    case (state_q[i])
                        E_PEND:   state_q[i] <= rsp_hit[i] ? E_IDLE : E_DRAIN;
                        E_FILLED: state_q[i] <= E_IDLE;
                        E_DRAIN:  if (rsp_hit[i]) state_q[i] <= E_IDLE;
                        default:  state_q[i] <= state_q[i];
                    endcase
                end else if (accept && alloc_ptr == PW'(i)) begin
                    state_q[i] <= E_PEND;
                end else if (rsp_hit[i]) begin
                    if (state_q[i] == E_PEND) begin
                        state_q[i] <= E_FILLED;
                    end else if (state_q[i] == E_DRAIN) begin
                        state_q[i] <= E_IDLE;
                    end
                end else if (deliver && dlvr_ptr == PW'(i)) begin
                    state_q[i] <= E_IDLE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (accept && alloc_ptr == PW'(i)) begin
                addr_q[i] <= line_addr;
            end
            if (!flush && rsp_hit[i] && state_q[i] == E_PEND) begin
                data_q[i] <= ic_fb_rsp_nnn.data;
            end
        end
    end

`ifndef SYNTHESIS
    logic rsp_legal;

    always_comb begin
        rsp_legal = 1'b0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (rsp_hit[i] && (state_q[i] == E_PEND || state_q[i] == E_DRAIN)) begin
                rsp_legal = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && ic_fb_rsp_nnn.valid) begin
            assert (rsp_legal);
        end
    end
`endif
endmodule

// File: tb/tb_fetch_fill_buffer.sv
// tb/tb_fetch_fill_buffer.sv - directed self-checking bench for fetch_fill_buffer
module tb_fetch_fill_buffer;
    import fetch_fill_buffer_pkg::*;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              req_valid = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic              req_ready;
    logic              flush = 1'b0;
    t_mem_req          ic_req;
    t_mem_rsp          ic_rsp;
    t_mem_rsp          auto_rsp;
    t_mem_rsp          man_rsp = '0;
    logic              auto_mode = 1'b1;
    logic              rsp_valid;
    logic [ADDR_W-1:0] rsp_addr;
    t_cl               rsp_data;
    logic              rsp_ready = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;
    int sched   [4];
    logic [31:0] id_addr [4];
    logic [31:0] exp_q   [4];

    fetch_fill_buffer #(.NUM_ENTRIES(4)) dut (
        .clk             (clk),
        .reset           (reset),
        .fe_fb_req_valid (req_valid),
        .fe_fb_req_addr  (req_addr),
        .fe_fb_req_ready (req_ready),
        .flush           (flush),
        .fb_ic_req_nnn   (ic_req),
        .ic_fb_rsp_nnn   (ic_rsp),
        .fb_fe_rsp_valid (rsp_valid),
        .fb_fe_rsp_addr  (rsp_addr),
        .fb_fe_rsp_data  (rsp_data),
        .fe_fb_rsp_ready (rsp_ready)
    );

    always #5 clk = ~clk;

    // IROM word w holds {16'hBEEF, w}
    function automatic t_cl line_data(input logic [31:0] a);
        t_cl d;
        for (int k = 0; k < CL_SZ_WORDS; k++) begin
            d.W[k] = {16'hBEEF, 16'(a[31:2]) + 16'(k)};
        end
        return d;
    endfunction

    // Stub icache with one cycle of latency, answering in request order
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            auto_rsp <= '0;
        end else begin
            auto_rsp.valid <= ic_req.valid;
            auto_rsp.id    <= ic_req.id;
            auto_rsp.data  <= line_data(ic_req.addr);
        end
    end

    assign ic_rsp = auto_mode ? auto_rsp : man_rsp;

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        req_valid = 1'b0;
        flush     = 1'b0;
        rsp_ready = 1'b0;
        man_rsp   = '0;
        repeat (2) tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic set_rsp(input int id, input logic [31:0] a);
        man_rsp.valid = 1'b1;
        man_rsp.id    = ID_W'(id);
        man_rsp.data  = line_data(a);
    endtask

    task automatic run_sched(input string tag);
        int n;
        n = 0;
        for (int c = 0; c < 12; c++) begin
            if (c < 4) set_rsp(sched[c], id_addr[sched[c]]);
            else man_rsp = '0;
            #1;
            if (rsp_valid) begin
                if (n < 4) begin
                    chk({tag, "_addr"}, 128'(rsp_addr), 128'(exp_q[n]));
                    chk({tag, "_data"}, rsp_data, line_data(exp_q[n]));
                end
                n++;
            end
            tick();
        end
        man_rsp = '0;
        chk({tag, "_count"}, 128'(n), 128'(4));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        logic acc;
        logic [31:0] e2 [5];

        #2;
        chk("rst_ready", 128'(req_ready), 128'(0));
        chk("rst_valid", 128'(rsp_valid), 128'(0));
        chk("rst_icreq", 128'(ic_req), 128'(0));
        do_reset();

        // 1: single request, LATENCY=1 icache
        auto_mode = 1'b1;
        req_valid = 1'b1;
        req_addr  = 32'h44;
        #1 chk("t1_ready", 128'(req_ready), 128'(1));
        tick();
        req_valid = 1'b0;
        #1;
        chk("t1_ic_valid", 128'(ic_req.valid), 128'(1));
        chk("t1_ic_id", 128'(ic_req.id), 128'(0));
        chk("t1_ic_addr", 128'(ic_req.addr), 128'(32'h40));
        chk("t1_n1_valid", 128'(rsp_valid), 128'(0));
        tick();
        #1 chk("t1_n2_valid", 128'(rsp_valid), 128'(0));
        tick();
        #1;
        chk("t1_n3_valid", 128'(rsp_valid), 128'(1));
        chk("t1_addr", 128'(rsp_addr), 128'(32'h40));
        chk("t1_data", rsp_data, line_data(32'h40));
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        #1 chk("t1_after_valid", 128'(rsp_valid), 128'(0));

        // 2: five back-to-back requests against a stalled consumer
        do_reset();
        auto_mode = 1'b1;
        for (int k = 0; k < 4; k++) begin
            req_valid = 1'b1;
            req_addr  = 32'(k * 64);
            #1 chk("t2_ready", 128'(req_ready), 128'(1));
            tick();
        end
        req_addr = 32'h100;
        #1 chk("t2_full_ready", 128'(req_ready), 128'(0));
        repeat (3) tick();
        #1;
        chk("t2_full_ready2", 128'(req_ready), 128'(0));
        chk("t2_head_valid", 128'(rsp_valid), 128'(1));
        chk("t2_head_addr", 128'(rsp_addr), 128'(0));
        tick();
        #1 chk("t2_hold_data", rsp_data, line_data(32'h0));
        e2[0] = 32'h0;  e2[1] = 32'h40; e2[2] = 32'h80;
        e2[3] = 32'hC0; e2[4] = 32'h100;
        rsp_ready = 1'b1;
        n = 0;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (rsp_valid) begin
                if (n < 5) begin
                    chk("t2_addr", 128'(rsp_addr), 128'(e2[n]));
                    chk("t2_data", rsp_data, line_data(e2[n]));
                end
                n++;
            end
            acc = req_valid & req_ready;
            tick();
            if (acc) req_valid = 1'b0;
        end
        chk("t2_count", 128'(n), 128'(5));
        req_valid = 1'b0;
        rsp_ready = 1'b0;

        // 3: out-of-order fills, in-order delivery
        do_reset();
        auto_mode = 1'b0;
        for (int k = 0; k < 4; k++) begin
            req_valid  = 1'b1;
            req_addr   = 32'h200 + 32'(k * 64);
            id_addr[k] = req_addr;
            exp_q[k]   = req_addr;
            #1 chk("t3_ready", 128'(req_ready), 128'(1));
            tick();
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        sched[0] = 2; sched[1] = 0; sched[2] = 3; sched[3] = 1;
        run_sched("t3");

        // 4: flush with two PEND entries and one FILLED entry
        do_reset();
        auto_mode = 1'b0;
        for (int k = 0; k < 3; k++) begin
            req_valid = 1'b1;
            req_addr  = 32'h600 + 32'(k * 64);
            #1 chk("t4_ready", 128'(req_ready), 128'(1));
            tick();
        end
        req_valid = 1'b0;
        set_rsp(2, 32'h680);
        tick();
        man_rsp   = '0;
        flush     = 1'b1;
        req_valid = 1'b1;
        req_addr  = 32'h700;
        rsp_ready = 1'b1;
        #1;
        chk("t4_flush_ready", 128'(req_ready), 128'(0));
        chk("t4_flush_valid", 128'(rsp_valid), 128'(0));
        tick();
        flush = 1'b0;
        #1;
        chk("t4_c0_ready", 128'(req_ready), 128'(1));
        chk("t4_c0_valid", 128'(rsp_valid), 128'(0));
        tick();
        req_addr = 32'h740;
        set_rsp(0, 32'h600);
        #1;
        chk("t4_drain_ready", 128'(req_ready), 128'(0));
        chk("t4_ic_id", 128'(ic_req.id), 128'(3));
        chk("t4_ic_addr", 128'(ic_req.addr), 128'(32'h700));
        chk("t4_c1_valid", 128'(rsp_valid), 128'(0));
        tick();
        set_rsp(1, 32'h640);
        #1;
        chk("t4_reuse_ready", 128'(req_ready), 128'(1));
        chk("t4_c2_valid", 128'(rsp_valid), 128'(0));
        tick();
        req_valid = 1'b0;
        set_rsp(3, 32'h700);
        #1;
        chk("t4_c3_valid", 128'(rsp_valid), 128'(0));
        chk("t4_ic_id0", 128'(ic_req.id), 128'(0));
        chk("t4_ic_addr0", 128'(ic_req.addr), 128'(32'h740));
        tick();
        set_rsp(0, 32'h740);
        #1;
        chk("t4_c4_valid", 128'(rsp_valid), 128'(1));
        chk("t4_c4_addr", 128'(rsp_addr), 128'(32'h700));
        chk("t4_c4_data", rsp_data, line_data(32'h700));
        tick();
        man_rsp = '0;
        #1;
        chk("t4_c5_valid", 128'(rsp_valid), 128'(1));
        chk("t4_c5_addr", 128'(rsp_addr), 128'(32'h740));
        chk("t4_c5_data", rsp_data, line_data(32'h740));
        tick();
        #1 chk("t4_c6_valid", 128'(rsp_valid), 128'(0));

        // 5: flush, fill of the head entry and consumer ready in one cycle
        do_reset();
        auto_mode = 1'b0;
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        req_addr  = 32'h800;
        #1 chk("t5_ready", 128'(req_ready), 128'(1));
        tick();
        req_valid = 1'b0;
        flush     = 1'b1;
        set_rsp(0, 32'h800);
        #1 chk("t5_flush_valid", 128'(rsp_valid), 128'(0));
        tick();
        flush   = 1'b0;
        man_rsp = '0;
        #1 chk("t5_post_valid", 128'(rsp_valid), 128'(0));
        for (int k = 0; k < 4; k++) begin
            req_valid = 1'b1;
            req_addr  = 32'h900 + 32'(k * 64);
            id_addr[(k + 1) % 4] = req_addr;
            exp_q[k] = req_addr;
            #1 chk("t5_reuse_ready", 128'(req_ready), 128'(1));
            tick();
        end
        req_valid = 1'b0;
        #1;
        chk("t5_ic_id", 128'(ic_req.id), 128'(0));
        chk("t5_ic_addr", 128'(ic_req.addr), 128'(32'h9C0));
        sched[0] = 1; sched[1] = 2; sched[2] = 3; sched[3] = 0;
        run_sched("t5");
        rsp_ready = 1'b0;

        // 6: asynchronous reset mid-stream
        do_reset();
        auto_mode = 1'b1;
        req_valid = 1'b1;
        req_addr  = 32'hA00;
        tick();
        req_valid = 1'b0;
        repeat (2) tick();
        req_valid = 1'b1;
        req_addr  = 32'hA40;
        tick();
        req_valid = 1'b0;
        #1;
        chk("t6_pre_valid", 128'(rsp_valid), 128'(1));
        chk("t6_pre_ready", 128'(req_ready), 128'(1));
        chk("t6_pre_ic", 128'(ic_req.valid), 128'(1));
        #1 reset = 1'b1;
        #1;
        chk("t6_rst_valid", 128'(rsp_valid), 128'(0));
        chk("t6_rst_ready", 128'(req_ready), 128'(0));
        chk("t6_rst_ic", 128'(ic_req), 128'(0));
        repeat (2) tick();
        reset     = 1'b0;
        req_valid = 1'b1;
        req_addr  = 32'hB04;
        #1 chk("t6_ready", 128'(req_ready), 128'(1));
        tick();
        req_valid = 1'b0;
        #1;
        chk("t6_ic_id", 128'(ic_req.id), 128'(0));
        chk("t6_ic_addr", 128'(ic_req.addr), 128'(32'hB00));
        repeat (2) tick();
        #1;
        chk("t6_valid", 128'(rsp_valid), 128'(1));
        chk("t6_addr", 128'(rsp_addr), 128'(32'hB00));
        chk("t6_data", rsp_data, line_data(32'hB00));
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        #1 chk("t6_done_valid", 128'(rsp_valid), 128'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
